// File: rtl/rv32i_pkg.sv
// Shared RV32I front-end definitions: ISA constants, fetch FSM encoding, bubble-counter width.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rv32i_pkg;

    localparam int          XLEN        = 32;
    localparam int          INSTR_BYTES = 4;
    localparam logic [6:0]  OPC_BRANCH  = 7'b1100011;

    // Wide enough for the largest legal bubble count (7).
    localparam int          BUB_CNT_W   = 3;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/branch_target_adder.sv
// Sign-extends a halfword-scaled immediate and adds it to a base PC (branch or JAL targets).
// Latency: combinational.
// Backpressure: none.
module branch_target_adder
    import rv32i_pkg::*;
#(
    parameter int IMM_W = 12
) (
    input  logic [XLEN-1:0]  base_pc,
    input  logic [IMM_W-1:0] imm,
    output logic [XLEN-1:0]  target
);

    logic [XLEN-1:0] offset;

    // imm holds bits [IMM_W:1] of the byte offset; bit 0 is implicitly zero.
    assign offset = {{(XLEN-IMM_W-1){imm[IMM_W-1]}}, imm, 1'b0};
    assign target = base_pc + offset;

endmodule

// File: rtl/fetch_pc_redirect.sv
// Fetch PC owner: +4 per accepted fetch, redirect on EX taken branch with IF/ID + ID/EX flush.
// Latency: redirect/flush combinational; new PC presented next cycle after REDIRECT_BUBBLES bubbles.
// Backpressure: if_ready_i low or stall_i high holds the PC; optional trap under MISALIGN_TRAP_EN.
module fetch_pc_redirect
    import rv32i_pkg::*;
#(
    parameter logic [31:0] RESET_PC         = 32'h0000_0000,
    parameter int          REDIRECT_BUBBLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_i,
    input  logic        ex_valid_i,
    input  logic        ex_branch_i,
    input  logic [31:0] ex_pc_i,
    input  logic [11:0] ex_deviation_i,
    input  logic        if_ready_i,
    output logic [31:0] if_pc_o,
    output logic        if_valid_o,
    output logic        flush_if_id_o,
    output logic        flush_id_ex_o,
    output logic        redirect_o,
    output logic        misalign_o,
    output logic [31:0] mtval_o
);

    localparam logic [BUB_CNT_W-1:0] BUB_INIT = BUB_CNT_W'(REDIRECT_BUBBLES);

    fetch_state_e         state_q;
    logic [BUB_CNT_W-1:0] bub_cnt_q;
    logic [XLEN-1:0]      pc_q;

    logic [XLEN-1:0]      target;
    logic [XLEN-1:0]      load_pc;
    logic                 take;
    logic                 target_bad;
    logic                 do_redirect;
    logic                 advance;

    branch_target_adder #(.IMM_W(12)) u_target (
        .base_pc (ex_pc_i),
        .imm     (ex_deviation_i),
        .target  (target)
    );

    assign take = ex_valid_i & ex_branch_i & (state_q != ST_BOOT);

`ifdef MISALIGN_TRAP_EN
    assign target_bad = target[1];
    assign load_pc    = target;
`else
    // Without the trap, a halfword-aligned target is silently rounded down to a word.
    assign target_bad = 1'b0;
    assign load_pc    = target & ~32'h0000_0002;
`endif

    assign do_redirect = take & ~target_bad;
    assign advance     = (state_q == ST_RUN) & if_ready_i & ~stall_i & ~take;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_BOOT;
            bub_cnt_q <= '0;
            pc_q      <= RESET_PC;
        end else begin
            case (state_q)
                ST_BOOT: state_q <= ST_RUN;
                default: begin
                    if (do_redirect) begin
                        pc_q      <= load_pc;
                        state_q   <= ST_FLUSH;
                        bub_cnt_q <= BUB_INIT;
                    end else begin
                        if (advance)
                            pc_q <= pc_q + XLEN'(INSTR_BYTES);
                        // Bubbles drain even under stall so imem refill time is not extended.
                        if (state_q == ST_FLUSH) begin
                            bub_cnt_q <= bub_cnt_q - 1'b1;
                            if (bub_cnt_q <= BUB_CNT_W'(1))
                                state_q <= ST_RUN;
                        end
                    end
                end
            endcase
        end
    end

`ifdef MISALIGN_TRAP_EN
    logic        misalign_q;
    logic [31:0] mtval_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misalign_q <= 1'b0;
            mtval_q    <= '0;
        end else begin
            misalign_q <= take & target_bad;
            if (take & target_bad)
                mtval_q <= target;
        end
    end

    assign misalign_o = misalign_q;
    assign mtval_o    = mtval_q;
`else
    assign misalign_o = 1'b0;
    assign mtval_o    = '0;
`endif

    assign if_pc_o       = pc_q;
    assign if_valid_o    = (state_q == ST_RUN);
    assign flush_if_id_o = take;
    assign flush_id_ex_o = take;
    assign redirect_o    = do_redirect;

endmodule
